// File: rtl/updown_count_monitor.sv
// updown_count_monitor
//   Receive-side monitor for an up/down counter's output bus. Samples the
//   count code, recovers the counting direction (0 = up, 1 = down), and
//   flags wrap-around, direction reversals and illegal jumps. It also keeps
//   a saturating run length and a saturating error count.
//
// Ports
//   clk      rising-edge clock
//   clr      asynchronous active-high reset
//   valid    d carries a sample this cycle
//   d        observed count code
//   dir      recovered direction (0 = up, 1 = down)
//   locked   high while tracking a direction
//   step     pulse: last accepted sample was a legal +1/-1 step
//   wrap     pulse: that step wrapped (max->0 up, 0->max down)
//   dir_chg  pulse: tracked direction reversed
//   err      pulse: illegal transition
//   run_len  consecutive legal steps in the current direction (saturating)
//   err_cnt  total illegal transitions (saturating)
module updown_count_monitor #(
  parameter int WIDTH = 3,
  parameter int RUN_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid,
  input  logic [WIDTH-1:0] d,
  output logic             dir,
  output logic             locked,
  output logic             step,
  output logic             wrap,
  output logic             dir_chg,
  output logic             err,
  output logic [RUN_W-1:0] run_len,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {EMPTY, ACQ, TRK_UP, TRK_DN} state_t;
  typedef enum logic [1:0] {C_HOLD, C_UP, C_DN, C_ILL} cls_t;

  state_t           state;
  cls_t             cls;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  logic             wrap_hit;
  logic [RUN_W-1:0] run_inc;
  logic [ERR_W-1:0] err_inc;

  // Classify the sample by its modular distance from the previous one.
  always_comb begin
    delta = d - prev;
    cls   = C_ILL;
    if (delta == WIDTH'(1))      cls = C_UP;
    else if (delta == '1)        cls = C_DN;
    else if (delta == '0)        cls = C_HOLD;
    // For a legal step the wrap condition depends on prev alone.
    wrap_hit = ((cls == C_UP) && (prev == '1)) ||
               ((cls == C_DN) && (prev == '0));
    run_inc  = (run_len == '1) ? run_len : run_len + RUN_W'(1);
    err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= EMPTY;
      prev    <= '0;
      dir     <= 1'b0;
      locked  <= 1'b0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
      err     <= 1'b0;
      run_len <= '0;
      err_cnt <= '0;
    end else begin
      step    <= 1'b0;
      wrap    <= 1'b0;
      dir_chg <= 1'b0;
      err     <= 1'b0;
      if (valid) begin
        prev <= d;
        case (state)
          EMPTY: state <= ACQ;
          ACQ: begin
            case (cls)
              C_UP: begin
                state   <= TRK_UP;
                locked  <= 1'b1;
                dir     <= 1'b0;
                run_len <= RUN_W'(1);
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_DN: begin
                state   <= TRK_DN;
                locked  <= 1'b1;
                dir     <= 1'b1;
                run_len <= RUN_W'(1);
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_ILL: begin
                err     <= 1'b1;
                err_cnt <= err_inc;
              end
              C_HOLD: ;
            endcase
          end
          TRK_UP: begin
            case (cls)
              C_UP: begin
                run_len <= run_inc;
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_DN: begin
                state   <= TRK_DN;
                dir     <= 1'b1;
                dir_chg <= 1'b1;
                run_len <= RUN_W'(1);
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_ILL: begin
                state   <= ACQ;
                locked  <= 1'b0;
                err     <= 1'b1;
                err_cnt <= err_inc;
                run_len <= '0;
              end
              C_HOLD: ;
            endcase
          end
          TRK_DN: begin
            case (cls)
              C_DN: begin
                run_len <= run_inc;
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_UP: begin
                state   <= TRK_UP;
                dir     <= 1'b0;
                dir_chg <= 1'b1;
                run_len <= RUN_W'(1);
                step    <= 1'b1;
                wrap    <= wrap_hit;
              end
              C_ILL: begin
                state   <= ACQ;
                locked  <= 1'b0;
                err     <= 1'b1;
                err_cnt <= err_inc;
                run_len <= '0;
              end
              C_HOLD: ;
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_count_monitor.sv
`timescale 1ns/1ps
module tb_updown_count_monitor;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] d = '0;
  logic       dir, locked, step, wrap, dir_chg, err;
  logic [7:0] run_len;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [17:0] expq[$];
  string       tagq[$];
  logic [17:0] obs;

  updown_count_monitor #(.WIDTH(3), .RUN_W(8), .ERR_W(4)) dut (
    .clk(clk), .clr(clr), .valid(valid), .d(d),
    .dir(dir), .locked(locked), .step(step), .wrap(wrap),
    .dir_chg(dir_chg), .err(err), .run_len(run_len), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  assign obs = {dir, locked, step, wrap, dir_chg, err, run_len, err_cnt};

  // {dir, locked, step, wrap, dir_chg, err, run_len, err_cnt}
  function automatic logic [17:0] ex(input logic dr, input logic lk, input logic st,
                                     input logic wr, input logic dc, input logic er,
                                     input int unsigned rl, input int unsigned ec);
    return {dr, lk, st, wr, dc, er, rl[7:0], ec[3:0]};
  endfunction

  task automatic check_out();
    logic [17:0] e;
    string t;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed %h expected <none>", obs);
    end else begin
      e = expq.pop_front();
      t = tagq.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // Drive one sample on the falling edge, expect the response 1 ns after the next rising edge.
  task automatic smp(input logic v, input logic [2:0] dv, input string tag, input logic [17:0] e);
    @(negedge clk);
    valid = v;
    d = dv;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic clr_pulse(input string tag);
    @(posedge clk);
    #3;
    clr = 1'b1;
    expq.push_back('0);
    tagq.push_back(tag);
    #1;
    check_out();
    #2;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] dv;
    int unsigned rl, ec;
    #2 clr = 1'b1;
    #2;
    expq.push_back('0);
    tagq.push_back("reset");
    check_out();
    @(negedge clk);
    clr = 1'b0;

    smp(1, 3'd5, "first_acq",  ex(0,0,0,0,0,0,0,0));
    smp(1, 3'd6, "acq_up",     ex(0,1,1,0,0,0,1,0));
    smp(1, 3'd7, "trk_up",     ex(0,1,1,0,0,0,2,0));
    clr_pulse("clr_mid");
    smp(1, 3'd5, "post_clr",   ex(0,0,0,0,0,0,0,0));
    clr_pulse("clr_again");

    smp(1, 3'd6, "up6",        ex(0,0,0,0,0,0,0,0));
    smp(1, 3'd7, "up7",        ex(0,1,1,0,0,0,1,0));
    smp(1, 3'd0, "up0_wrap",   ex(0,1,1,1,0,0,2,0));
    smp(1, 3'd1, "up1",        ex(0,1,1,0,0,0,3,0));
    smp(1, 3'd1, "hold1",      ex(0,1,0,0,0,0,3,0));
    smp(1, 3'd0, "dn0_rev",    ex(1,1,1,0,1,0,1,0));
    smp(1, 3'd7, "dn7_wrap",   ex(1,1,1,1,0,0,2,0));
    smp(0, 3'd3, "gap",        ex(1,1,0,0,0,0,2,0));

    clr_pulse("clr_rev");
    smp(1, 3'd2, "rev2",       ex(0,0,0,0,0,0,0,0));
    smp(1, 3'd3, "rev3",       ex(0,1,1,0,0,0,1,0));
    smp(1, 3'd4, "rev4",       ex(0,1,1,0,0,0,2,0));
    smp(1, 3'd3, "rev3_dn",    ex(1,1,1,0,1,0,1,0));

    smp(1, 3'd2, "dn2",        ex(1,1,1,0,0,0,2,0));
    smp(1, 3'd3, "up3_rev",    ex(0,1,1,0,1,0,1,0));
    smp(1, 3'd6, "ill6",       ex(0,0,0,0,0,1,0,1));
    smp(1, 3'd7, "resync7",    ex(0,1,1,0,0,0,1,1));
    smp(1, 3'd7, "hold7",      ex(0,1,0,0,0,0,1,1));

    // Alternating 3/7 is a distance of 4 each time: always illegal.
    for (int i = 1; i <= 16; i++) begin
      dv = (i % 2 == 1) ? 3'd3 : 3'd7;
      ec = (1 + i > 15) ? 15 : 1 + i;
      smp(1, dv, "ill_sat", ex(0,0,0,0,0,1,0,ec));
    end

    // 300 up steps from prev=7; a gap and a HOLD are slipped in before step 100.
    for (int i = 1; i <= 300; i++) begin
      if (i == 100) begin
        smp(0, 3'd5, "sat_gap",  ex(0,1,0,0,0,0,99,15));
        smp(1, 3'd2, "sat_hold", ex(0,1,0,0,0,0,99,15));
      end
      dv = 3'((7 + i) % 8);
      rl = (i > 255) ? 255 : i;
      smp(1, dv, "run_sat", ex(0,1,1,(i % 8 == 1),0,0,rl,15));
    end

    smp(1, 3'd2, "sat_rev",    ex(1,1,1,0,1,0,1,15));
    smp(1, 3'd1, "dn1",        ex(1,1,1,0,0,0,2,15));
    smp(1, 3'd0, "dn0",        ex(1,1,1,0,0,0,3,15));
    smp(1, 3'd7, "dn7_wrap2",  ex(1,1,1,1,0,0,4,15));
    smp(1, 3'd0, "wrap_rev",   ex(0,1,1,1,1,0,1,15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
